// File: rtl/clk_div_ctrl_pkg.sv
// Shared encodings for the programmable clock divider controller:
// configuration mode values, FSM states and the mode-to-state decode.
package clk_div_ctrl_pkg;

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_CONT  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BURST
    } state_e;

    // Reserved mode 11 and zero-length bursts both behave as STOP.
    function automatic state_e target_state(input logic [1:0] mode, input logic burst_nz);
        state_e s;
        s = IDLE;
        if (mode == MODE_CONT) begin
            s = RUN;
        end else if (mode == MODE_BURST && burst_nz) begin
            s = BURST;
        end
        return s;
    endfunction

endpackage

// File: rtl/div_counter.sv
// Half-period counter: counts while enabled and wraps at the active terminal value.
// The live count is exported only when CLK_DIV_CTRL_STATUS_EN is defined.
module div_counter
    import clk_div_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 24,
    parameter int DEFAULT_MAX = 6000000 - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic [COUNT_WIDTH:0] load_max_i,
    output logic                 tc_o
`ifdef CLK_DIV_CTRL_STATUS_EN
    ,
    output logic [COUNT_WIDTH:0] count_o
`endif
);

    logic [COUNT_WIDTH:0] count_q, count_d;
    logic [COUNT_WIDTH:0] max_q, max_d;

    assign tc_o = en_i && (count_q == max_q);

    // A new terminal value only lands on a TC or in IDLE, where the count is zero.
    always_comb begin
        count_d = count_q + 1'b1;
        if (!en_i || tc_o) begin
            count_d = '0;
        end
        max_d = load_i ? load_max_i : max_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            max_q   <= (COUNT_WIDTH + 1)'(DEFAULT_MAX);
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

`ifdef CLK_DIV_CTRL_STATUS_EN
    assign count_o = count_q;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable divider controller with valid/ready configuration and glitch-free out.
// Define CLK_DIV_CTRL_STATUS_EN to add the count_o and period_cnt status outputs.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 24,
    parameter int DEFAULT_MAX = 6000000 - 1,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [1:0]             cfg_mode,
    input  logic [COUNT_WIDTH:0]   cfg_max,
    input  logic [BURST_WIDTH-1:0] cfg_burst,
    output logic                   out,
    output logic                   tick,
    output logic                   busy,
    output logic                   done
`ifdef CLK_DIV_CTRL_STATUS_EN
    ,
    output logic [COUNT_WIDTH:0]   count_o,
    output logic [15:0]            period_cnt
`endif
);

    state_e                 state_q, state_d, tgt;
    logic                   out_q, out_d, tick_q, done_q, done_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [1:0]             pend_mode_q, pend_mode_d;
    logic [COUNT_WIDTH:0]   pend_max_q, pend_max_d;
    logic [BURST_WIDTH-1:0] pend_burst_q, pend_burst_d;
    logic [BURST_WIDTH-1:0] burst_left_q, burst_left_d;
    logic                   accept, tc, apply;
    logic [1:0]             apply_mode;
    logic [COUNT_WIDTH:0]   apply_max;
    logic [BURST_WIDTH-1:0] apply_burst;

    assign cfg_ready = !pend_valid_q;
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign tick      = tick_q;
    assign done      = done_q;

    div_counter #(
        .COUNT_WIDTH(COUNT_WIDTH),
        .DEFAULT_MAX(DEFAULT_MAX)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .en_i      (busy),
        .load_i    (apply),
        .load_max_i(apply_max),
        .tc_o      (tc)
`ifdef CLK_DIV_CTRL_STATUS_EN
        ,
        .count_o   (count_o)
`endif
    );

    // IDLE applies a config at once (including one caught as a burst ended);
    // otherwise it waits in the pending slot for a later TC.
    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        done_d       = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_mode_d  = pend_mode_q;
        pend_max_d   = pend_max_q;
        pend_burst_d = pend_burst_q;
        burst_left_d = burst_left_q;
        apply        = 1'b0;
        apply_mode   = pend_mode_q;
        apply_max    = pend_max_q;
        apply_burst  = pend_burst_q;
        tgt          = IDLE;

        if (state_q == IDLE) begin
            out_d = 1'b0;
            if (pend_valid_q) begin
                apply = 1'b1;
            end else if (accept) begin
                apply       = 1'b1;
                apply_mode  = cfg_mode;
                apply_max   = cfg_max;
                apply_burst = cfg_burst;
            end
        end else begin
            if (accept) begin
                pend_valid_d = 1'b1;
                pend_mode_d  = cfg_mode;
                pend_max_d   = cfg_max;
                pend_burst_d = cfg_burst;
            end
            if (tc) begin
                out_d = !out_q;
                if (pend_valid_q) begin
                    apply = 1'b1;
                end else if (state_q == BURST && out_q) begin
                    burst_left_d = burst_left_q - 1'b1;
                    if (burst_left_q == BURST_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        end

        if (apply) begin
            tgt          = target_state(apply_mode, apply_burst != '0);
            pend_valid_d = 1'b0;
            state_d      = tgt;
            burst_left_d = (tgt == BURST) ? apply_burst : '0;
            if (tgt == IDLE) begin
                out_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_q        <= 1'b0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_mode_q  <= MODE_STOP;
            pend_max_q   <= '0;
            pend_burst_q <= '0;
            burst_left_q <= '0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            tick_q       <= tc;
            done_q       <= done_d;
            pend_valid_q <= pend_valid_d;
            pend_mode_q  <= pend_mode_d;
            pend_max_q   <= pend_max_d;
            pend_burst_q <= pend_burst_d;
            burst_left_q <= burst_left_d;
        end
    end

`ifdef CLK_DIV_CTRL_STATUS_EN
    logic [15:0] period_q, period_d;

    // A full period completes on each falling edge of out.
    always_comb begin
        period_d = period_q;
        if (state_d == IDLE) begin
            period_d = '0;
        end else if (tc && out_q && period_q != 16'hFFFF) begin
            period_d = period_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end

    assign period_cnt = period_q;
`endif

endmodule
